// File: rtl/tpu_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_out_pkg
//  Description : Shared constants, FSM state encodings and byte-mask helper
//                for the TPU output writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_out_pkg;

    localparam int TPU_TILE        = 4;
    localparam int TPU_DATA_W      = 8;
    localparam int WORD_SIZE       = TPU_TILE * TPU_DATA_W;
    localparam int GBUFF_ADDR_SIZE = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_TILE = 2'd1;
    localparam logic [1:0] ST_WRITE     = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // Column 4*tc+j is inside the n-column result matrix
    function automatic logic byte_ok(input logic [1:0] tc, input int j, input logic [3:0] n);
        return (int'(tc) * TPU_TILE + j) < int'(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_out_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_out_addr_gen
//  Description : Tile/row counters for the output writer. Counters always point
//                at the next row to be written; o_addr is its GBUFF_OUT index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpu_out_addr_gen
    import tpu_out_pkg::*;
#(
    parameter int ADDR_W = GBUFF_ADDR_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [3:0]        i_m,
    input  logic [3:0]        i_n,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_r,
    output logic [1:0]        o_tc,
    output logic [3:0]        o_n,
    output logic              o_mid_tile,
    output logic              o_all_done
);

    logic [3:0] r_m, r_n;
    logic [2:0] r_row_off, r_row_tiles;
    logic [1:0] r_tr, r_tc, r_r;
    logic       r_all_done;

    logic [3:0] w_m_nxt, w_n_nxt;
    logic [2:0] w_row_off_nxt, w_row_tiles_nxt;
    logic [1:0] w_tr_nxt, w_tc_nxt, w_r_nxt;
    logic       w_all_done_nxt;

    logic [4:0]        w_rem;
    logic [2:0]        w_rows;
    logic              w_last_row, w_last_tc, w_last_tr;
    logic [ADDR_W-1:0] w_row_idx;

    // Rows left in the current row-tile, clipped to the tile edge
    always_comb begin
        w_rem      = {1'b0, r_m} - {1'b0, r_tr, 2'b00};
        w_rows     = (w_rem >= 5'd4) ? 3'd4 : w_rem[2:0];
        w_last_row = ({1'b0, r_r}  == (w_rows - 3'd1));
        w_last_tc  = ({1'b0, r_tc} == (r_row_off - 3'd1));
        w_last_tr  = ({1'b0, r_tr} == (r_row_tiles - 3'd1));
        w_row_idx  = ADDR_W'({r_tr, 2'b00}) + ADDR_W'(r_r);
        o_addr     = w_row_idx * ADDR_W'(r_row_off) + ADDR_W'(r_tc);
    end

    // Next-state: load a new job, or step past the row just issued
    always_comb begin
        w_m_nxt          = r_m;
        w_n_nxt          = r_n;
        w_row_off_nxt    = r_row_off;
        w_row_tiles_nxt  = r_row_tiles;
        w_tr_nxt         = r_tr;
        w_tc_nxt         = r_tc;
        w_r_nxt          = r_r;
        w_all_done_nxt   = r_all_done;
        if (i_load) begin
            w_m_nxt         = i_m;
            w_n_nxt         = i_n;
            w_row_off_nxt   = 3'(({1'b0, i_n} + 5'd3) >> 2);
            w_row_tiles_nxt = 3'(({1'b0, i_m} + 5'd3) >> 2);
            w_tr_nxt        = 2'd0;
            w_tc_nxt        = 2'd0;
            w_r_nxt         = 2'd0;
            w_all_done_nxt  = 1'b0;
        end else if (i_step) begin
            if (w_last_row) begin
                w_r_nxt = 2'd0;
                if (w_last_tc) begin
                    w_tc_nxt = 2'd0;
                    if (w_last_tr) begin
                        w_tr_nxt       = 2'd0;
                        w_all_done_nxt = 1'b1;
                    end else begin
                        w_tr_nxt = r_tr + 2'd1;
                    end
                end else begin
                    w_tc_nxt = r_tc + 2'd1;
                end
            end else begin
                w_r_nxt = r_r + 2'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m         <= '0;
            r_n         <= '0;
            r_row_off   <= '0;
            r_row_tiles <= '0;
            r_tr        <= '0;
            r_tc        <= '0;
            r_r         <= '0;
            r_all_done  <= 1'b0;
        end else begin
            r_m         <= w_m_nxt;
            r_n         <= w_n_nxt;
            r_row_off   <= w_row_off_nxt;
            r_row_tiles <= w_row_tiles_nxt;
            r_tr        <= w_tr_nxt;
            r_tc        <= w_tc_nxt;
            r_r         <= w_r_nxt;
            r_all_done  <= w_all_done_nxt;
        end
    end

    assign o_r        = r_r;
    assign o_tc       = r_tc;
    assign o_n        = r_n;
    assign o_mid_tile = (r_r != 2'd0);
    assign o_all_done = r_all_done;

endmodule
`default_nettype wire

// File: rtl/tpu_out_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_out_writer
//  Description : Accepts 4x4 int8 result tiles and writes them row-major into
//                GBUFF_OUT as packed 32-bit words; raises done when the whole
//                m x n matrix is stored.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpu_out_writer
    import tpu_out_pkg::*;
#(
    parameter int DATA_W = TPU_DATA_W,
    parameter int TILE   = TPU_TILE,
    parameter int WORD_W = WORD_SIZE,
    parameter int ADDR_W = GBUFF_ADDR_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [3:0]               m,
    input  logic [3:0]               n,
    input  logic                     tile_valid,
    output logic                     tile_ready,
    input  logic [TILE*TILE*DATA_W-1:0] tile_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [WORD_W-1:0]        wr_data,
    output logic                     done
);

    logic [1:0]                 r_state, w_state_nxt;
    logic [TILE*TILE*DATA_W-1:0] r_tile, w_tile_nxt;
    logic                       r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0]          r_wr_addr, w_wr_addr_nxt;
    logic [WORD_W-1:0]          r_wr_data, w_wr_data_nxt;
    logic                       r_done, w_done_nxt;

    logic                       w_load, w_step;
    logic [ADDR_W-1:0]          w_addr;
    logic [1:0]                 w_r, w_tc;
    logic [3:0]                 w_n;
    logic                       w_mid_tile, w_all_done;
    logic [TILE*TILE*DATA_W-1:0] w_src;
    logic [WORD_W-1:0]          w_row, w_packed;

    tpu_out_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_m        (m),
        .i_n        (n),
        .i_step     (w_step),
        .o_addr     (w_addr),
        .o_r        (w_r),
        .o_tc       (w_tc),
        .o_n        (w_n),
        .o_mid_tile (w_mid_tile),
        .o_all_done (w_all_done)
    );

    // Row 0 is written straight from the incoming tile on acceptance
    assign w_src = (r_state == ST_WAIT_TILE) ? tile_data : r_tile;
    assign w_row = w_src[w_r*WORD_W +: WORD_W];

    generate
        for (genvar j = 0; j < TILE; j++) begin : g_pack
            assign w_packed[j*DATA_W +: DATA_W] =
                byte_ok(w_tc, j, w_n) ? w_row[j*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    // FSM next-state and registered-output computation
    always_comb begin
        w_state_nxt   = r_state;
        w_tile_nxt    = r_tile;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = r_done;
        w_load        = 1'b0;
        w_step        = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_done_nxt = 1'b0;
                    w_state_nxt = (m == 4'd0 || n == 4'd0) ? ST_DONE : ST_WAIT_TILE;
                end else if (r_state == ST_DONE) begin
                    w_done_nxt = 1'b1;
                end
            end
            ST_WAIT_TILE: begin
                if (tile_valid) begin
                    w_tile_nxt    = tile_data;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = w_addr;
                    w_wr_data_nxt = w_packed;
                    w_step        = 1'b1;
                    w_state_nxt   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_mid_tile) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = w_addr;
                    w_wr_data_nxt = w_packed;
                    w_step        = 1'b1;
                end else if (w_all_done) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_TILE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tile    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tile    <= w_tile_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign tile_ready = (r_state == ST_WAIT_TILE);
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tpu_out_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tpu_out_writer
//  Description : Directed self-checking bench for tpu_out_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_out_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   m, n;
    logic         tile_valid;
    logic         tile_ready;
    logic [127:0] tile_data;
    logic         wr_en;
    logic [7:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         done;

    int total = 0;
    int bad   = 0;
    int overlap = 0;
    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];

    tpu_out_writer u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .m          (m),
        .n          (n),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_data  (tile_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Capture every write and any ready/write overlap
    always @(negedge clk) begin
        if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (wr_en && tile_ready) overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // elem(r,c) = id*16 + r*4 + c
    function automatic logic [127:0] make_tile(input int id);
        logic [127:0] t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[(r*4+c)*8 +: 8] = 8'(id*16 + r*4 + c);
        return t;
    endfunction

    task automatic start_job(input logic [3:0] mm, input logic [3:0] nn);
        m = mm;
        n = nn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_tile(input int id, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        tile_data  = make_tile(id);
        tile_valid = 1'b1;
        t = 0;
        while (!tile_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("tile_timeout", 64'd1, 64'd0);
        @(negedge clk);
        tile_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", 64'(done), 64'd1);
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp2[12];
        int seen[36];
        int t;
        logic [31:0] w35;
        exp2 = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 9, 11};

        rst = 1'b1; start = 1'b0; m = '0; n = '0;
        tile_valid = 1'b0; tile_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(tile_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_addr",  64'(wr_addr), 64'd0);
        chk("rst_data",  64'(wr_data), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single 4x4 tile
        clear_q();
        start_job(4'd4, 4'd4);
        send_tile(0, 0);
        chk("t1_done_early", 64'(done), 64'd0);
        t = 0;
        while (wr_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t1_done_lat", 64'(done), 64'd1);
        chk("t1_count", 64'(q_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++) chk("t1_addr", 64'(q_addr[i]), 64'(i));
        if (q_data.size() == 4) begin
            chk("t1_word0", 64'(q_data[0]), 64'h03020100);
            chk("t1_word3", 64'(q_data[3]), 64'h0F0E0D0C);
        end

        // 2: 6x6, partial tiles in both directions
        clear_q();
        start_job(4'd6, 4'd6);
        for (int k = 0; k < 4; k++) send_tile(k, 0);
        wait_done();
        chk("t2_count", 64'(q_addr.size()), 64'd12);
        for (int i = 0; i < 12 && i < q_addr.size(); i++) chk("t2_addr", 64'(q_addr[i]), 64'(exp2[i]));
        if (q_data.size() == 12) begin
            chk("t2_t01_row0", 64'(q_data[4]), 64'h00001110);
            chk("t2_t01_row3", 64'(q_data[7]), 64'h00001D1C);
            chk("t2_t10_row1", 64'(q_data[9]), 64'h27262524);
        end

        // 3: 12x12 with random valid gaps
        clear_q();
        start_job(4'd12, 4'd12);
        for (int k = 0; k < 9; k++) send_tile(k, int'($urandom_range(0, 3)));
        wait_done();
        chk("t3_count", 64'(q_addr.size()), 64'd36);
        for (int i = 0; i < 36; i++) seen[i] = 0;
        w35 = '0;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] < 36) seen[q_addr[i]]++;
            if (q_addr[i] == 8'd35) w35 = q_data[i];
        end
        for (int i = 0; i < 36; i++) chk("t3_addr_once", 64'(seen[i]), 64'd1);
        chk("t3_word35", 64'(w35), 64'h8F8E8D8C);
        chk("t3_ready_vs_wr", 64'(overlap), 64'd0);

        // 4: empty matrices
        clear_q();
        start_job(4'd0, 4'd5);
        chk("t4a_done_s1", 64'(done), 64'd0);
        @(negedge clk);
        chk("t4a_done_s2", 64'(done), 64'd1);
        start_job(4'd7, 4'd0);
        chk("t4b_done_s1", 64'(done), 64'd0);
        @(negedge clk);
        chk("t4b_done_s2", 64'(done), 64'd1);
        repeat (4) @(negedge clk);
        chk("t4_no_writes", 64'(q_addr.size()), 64'd0);

        // 5: start during WRITE is ignored
        clear_q();
        start_job(4'd4, 4'd4);
        send_tile(3, 0);
        m = 4'd2; n = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("t5_count", 64'(q_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++) chk("t5_addr", 64'(q_addr[i]), 64'(i));
        if (q_data.size() == 4) chk("t5_word1", 64'(q_data[1]), 64'h37363534);
        start_job(4'd4, 4'd4);
        chk("t5_done_clear", 64'(done), 64'd0);

        // 6: reset in the middle of a tile write
        clear_q();
        send_tile(5, 0);
        chk("t6_mid_wr", 64'(wr_en), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_wr_en", 64'(wr_en), 64'd0);
        chk("t6_rst_ready", 64'(tile_ready), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_partial", 64'(q_addr.size()), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        clear_q();
        start_job(4'd4, 4'd4);
        send_tile(6, 0);
        wait_done();
        chk("t6_count", 64'(q_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++) chk("t6_addr", 64'(q_addr[i]), 64'(i));
        if (q_data.size() == 4) chk("t6_word2", 64'(q_data[2]), 64'h6B6A6968);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
